// File: rtl/timer_pkg.sv
// timer_pkg: shared width, channel select and channel FSM state types for timer_tick_gen.
package timer_pkg;
  localparam int TIMER_DIV_W = 16;
  typedef enum logic {TIMER_CH1 = 1'b0, TIMER_CH2 = 1'b1} timer_ch_e;
  typedef enum logic {CH_IDLE, CH_PEND} timer_ch_state_e;
endpackage

// File: rtl/timer_div_chan.sv
// timer_div_chan: one prescaler channel with a shadow divisor applied at the period boundary.
// Optional square-wave output when TIMER_TICK_SQUARE_EN is defined.
module timer_div_chan import timer_pkg::*; #(
  parameter int DIV_W   = TIMER_DIV_W,
  parameter int DIV_RST = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_acc,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_idle,
  output logic             o_tick
`ifdef TIMER_TICK_SQUARE_EN
  ,
  output logic             o_sq
`endif
);
  timer_ch_state_e r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, r_div, r_shadow, w_cnt_nxt;
  logic w_wrap, w_apply, w_acc;
  assign w_wrap  = i_en & (r_cnt == r_div - 1'b1);
  assign w_acc   = i_acc & (r_state == CH_IDLE);
  assign w_apply = (r_state == CH_PEND) & (~i_en | w_wrap);
  assign o_idle  = (r_state == CH_IDLE);
  // While halted, a pending update restarts the period from zero with the new divisor.
  assign w_cnt_nxt = w_wrap ? '0 : i_en ? r_cnt + 1'b1 : w_apply ? '0 : r_cnt;
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) w_state_nxt = CH_PEND;
    else if (w_apply) w_state_nxt = CH_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CH_IDLE;
      r_cnt    <= '0;
      r_div    <= DIV_W'(DIV_RST);
      r_shadow <= '0;
      o_tick   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_tick  <= w_wrap;
      if (w_acc) r_shadow <= (i_div == '0) ? DIV_W'(1) : i_div;
      if (w_apply) r_div <= r_shadow;
    end
  end
`ifdef TIMER_TICK_SQUARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_sq <= 1'b0;
    else o_sq <= o_sq ^ w_wrap;
  end
`endif
endmodule

// File: rtl/timer_tick_gen.sv
// timer_tick_gen: two independent programmable tick prescalers with a shared cfg port.
// Define TIMER_TICK_SQUARE_EN to add the sq1/sq2 square-wave outputs.
module timer_tick_gen import timer_pkg::*; #(
  parameter int DIV_W    = TIMER_DIV_W,
  parameter int DIV1_RST = 100,
  parameter int DIV2_RST = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick1,
  output logic             tick2
`ifdef TIMER_TICK_SQUARE_EN
  ,
  output logic             sq1,
  output logic             sq2
`endif
);
  logic w_idle1, w_idle2, w_acc1, w_acc2;
  assign cfg_ready = (cfg_sel == TIMER_CH2) ? w_idle2 : w_idle1;
  assign w_acc1 = cfg_valid & cfg_ready & (cfg_sel == TIMER_CH1);
  assign w_acc2 = cfg_valid & cfg_ready & (cfg_sel == TIMER_CH2);
  timer_div_chan #(.DIV_W(DIV_W), .DIV_RST(DIV1_RST)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_acc(w_acc1), .i_div(cfg_div),
    .o_idle(w_idle1), .o_tick(tick1)
`ifdef TIMER_TICK_SQUARE_EN
    , .o_sq(sq1)
`endif
  );
  timer_div_chan #(.DIV_W(DIV_W), .DIV_RST(DIV2_RST)) u_ch2 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_acc(w_acc2), .i_div(cfg_div),
    .o_idle(w_idle2), .o_tick(tick2)
`ifdef TIMER_TICK_SQUARE_EN
    , .o_sq(sq2)
`endif
  );
endmodule

// File: tb/tb_timer_tick_gen.sv
// tb_timer_tick_gen: directed check of tick timing, cfg handshake, halt stretch and reset.
module tb_timer_tick_gen;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, cfg_valid = 1'b0, cfg_sel = 1'b0;
  logic [15:0] cfg_div = '0;
  logic cfg_ready, tick1, tick2;
`ifdef TIMER_TICK_SQUARE_EN
  logic sq1, sq2;
`endif
  int checks = 0, failures = 0;
  timer_tick_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .tick1(tick1), .tick2(tick2)
`ifdef TIMER_TICK_SQUARE_EN
    , .sq1(sq1), .sq2(sq2)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tick1", tick1, 1'b0);
    chk("rst_tick2", tick2, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
`ifdef TIMER_TICK_SQUARE_EN
    chk("rst_sq1", sq1, 1'b0);
`endif
    adv(99);
    chk("t1_c99", tick1, 1'b0);
    adv(1);
    chk("t1_c100", tick1, 1'b1);
`ifdef TIMER_TICK_SQUARE_EN
    chk("sq1_c100", sq1, 1'b1);
`endif
    adv(1);
    chk("t1_c101", tick1, 1'b0);
    adv(48);
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_div = 16'd10;
    #1 chk("ready_c149", cfg_ready, 1'b1);
    adv(1);
    cfg_div = 16'd3;
    #1 chk("ready_ch1_pend", cfg_ready, 1'b0);
    cfg_sel = 1'b1; cfg_div = 16'd5;
    #1 chk("ready_ch2_idle", cfg_ready, 1'b1);
    adv(1);
    cfg_valid = 1'b0;
    #1 chk("ready_ch2_pend", cfg_ready, 1'b0);
    cfg_sel = 1'b0;
    adv(48);
    chk("t1_c199", tick1, 1'b0);
    chk("ready_c199", cfg_ready, 1'b0);
    adv(1);
    chk("t1_c200", tick1, 1'b1);
`ifdef TIMER_TICK_SQUARE_EN
    chk("sq1_c200", sq1, 1'b0);
`endif
    chk("ready_c200", cfg_ready, 1'b1);
    adv(9);
    chk("t1_c209", tick1, 1'b0);
    adv(1);
    chk("t1_c210", tick1, 1'b1);
    adv(10);
    chk("t1_c220", tick1, 1'b1);
    chk("t2_c220", tick2, 1'b0);
    cfg_valid = 1'b1; cfg_div = 16'd0;
    adv(1);
    cfg_valid = 1'b0;
    adv(8);
    chk("t1_c229", tick1, 1'b0);
    adv(1);
    chk("t1_c230", tick1, 1'b1);
    adv(1);
    chk("t1_div0_c231", tick1, 1'b1);
    adv(1);
    chk("t1_div0_c232", tick1, 1'b1);
    cfg_valid = 1'b1; cfg_div = 16'd1;
    adv(1);
    cfg_valid = 1'b0;
    chk("t1_c233", tick1, 1'b1);
    adv(2);
    chk("t1_div1_c235", tick1, 1'b1);
    chk("ready_c235", cfg_ready, 1'b1);
    cfg_sel = 1'b1;
    #1 chk("ch2_still_pend", cfg_ready, 1'b0);
    rst_n = 1'b0;
    #1 chk("async_rst_tick1", tick1, 1'b0);
    chk("async_rst_ready", cfg_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    adv(5);
    chk("t2_c5_after_rst", tick2, 1'b0);
    adv(994);
    chk("t2_c999", tick2, 1'b0);
    adv(1);
    chk("t2_c1000", tick2, 1'b1);
    chk("t1_c1000", tick1, 1'b1);
    adv(50);
    en = 1'b0;
    adv(1);
    chk("halt_t1", tick1, 1'b0);
    adv(36);
    chk("halt_t1_end", tick1, 1'b0);
    chk("halt_t2_end", tick2, 1'b0);
    en = 1'b1;
    adv(49);
    chk("t1_c1136", tick1, 1'b0);
    adv(1);
    chk("t1_c1137", tick1, 1'b1);
    adv(899);
    chk("t2_c2036", tick2, 1'b0);
    adv(1);
    chk("t2_c2037", tick2, 1'b1);
    adv(1);
    chk("t2_c2038", tick2, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
